// File: rtl/gamma_cp_serializer.sv
// Parallel-pixel to serial-plane serializer feeding a serial-input gamma corrector.
// Optional macro GAMMA_SER_SYNCRST_EN adds a synchronous clear input sr.
module gamma_cp_serializer #(
  parameter int DATA_WIDTH  = 10,
  parameter int NUM_CP      = 3,
  parameter int CPSEL_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef GAMMA_SER_SYNCRST_EN
  input  logic                   sr,
`endif
  input  logic                   ce,
  input  logic                   inpvalid,
  output logic                   inpready,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic [DATA_WIDTH-1:0]  din1,
  input  logic [DATA_WIDTH-1:0]  din2,
  output logic                   outvalid,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic [CPSEL_WIDTH-1:0] cpsel
);

  localparam int PW = 3 * DATA_WIDTH;

  if (!(NUM_CP == 2 || NUM_CP == 3) || CPSEL_WIDTH < 2) begin : g_param_err
    $error("gamma_cp_serializer: NUM_CP must be 2 or 3 and CPSEL_WIDTH >= 2");
  end

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  logic sr_w;
`ifdef GAMMA_SER_SYNCRST_EN
  assign sr_w = sr;
`else
  assign sr_w = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [PW-1:0]          mem_q [2];
  logic [PW-1:0]          mem_d [2];
  logic                   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]             count_q, count_d;
  logic [1:0]             plane_q, plane_d;
  logic                   outvalid_q, outvalid_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic [CPSEL_WIDTH-1:0] cpsel_q, cpsel_d;
  logic                   push, pop;

  // Ready is driven from registered count only; a same-cycle pop frees a slot next cycle.
  assign inpready = ce & ~rst & ~sr_w & (count_q != 2'd2);
  assign push     = inpvalid & inpready;

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    plane_d    = plane_q;
    outvalid_d = outvalid_q;
    dout_d     = dout_q;
    cpsel_d    = cpsel_q;
    pop        = 1'b0;
    if (ce) begin
      if (state_q == ST_EMIT) begin
        outvalid_d   = 1'b1;
        dout_d       = mem_q[rd_ptr_q][int'(plane_q) * DATA_WIDTH +: DATA_WIDTH];
        cpsel_d      = '0;
        cpsel_d[1:0] = plane_q;
        if (plane_q == 2'(NUM_CP - 1)) begin
          pop      = 1'b1;
          plane_d  = 2'd0;
          rd_ptr_d = ~rd_ptr_q;
        end else begin
          plane_d = plane_q + 2'd1;
        end
      end else begin
        outvalid_d = 1'b0;
      end
    end
    if (push) begin
      mem_d[wr_ptr_q] = {din2, din1, din0};
      wr_ptr_d        = ~wr_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // EMIT exactly tracks a non-empty buffer, so a fresh pixel starts on the next edge.
    state_d = (count_d != 2'd0) ? ST_EMIT : ST_IDLE;
    if (sr_w) begin
      state_d    = ST_IDLE;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
      plane_d    = 2'd0;
      outvalid_d = 1'b0;
      dout_d     = '0;
      cpsel_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      plane_q    <= 2'd0;
      outvalid_q <= 1'b0;
      dout_q     <= '0;
      cpsel_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      plane_q    <= plane_d;
      outvalid_q <= outvalid_d;
      dout_q     <= dout_d;
      cpsel_q    <= cpsel_d;
    end
  end

  assign outvalid = outvalid_q;
  assign dout     = dout_q;
  assign cpsel    = cpsel_q;

endmodule

// File: tb/tb_gamma_cp_serializer.sv
// Bench for gamma_cp_serializer: queue-based pixel model for NUM_CP=3, directed NUM_CP=2 run.
module tb_gamma_cp_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce, inpvalid, inpready, outvalid;
  logic [9:0] din0, din1, din2, dout;
  logic [1:0] cpsel;
  logic       ce2, iv2, ir2, ov2;
  logic [9:0] a0, a1, a2, do2;
  logic [1:0] cs2;

  always #5 clk = ~clk;

  gamma_cp_serializer #(.DATA_WIDTH(10), .NUM_CP(3), .CPSEL_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .ce(ce), .inpvalid(inpvalid), .inpready(inpready),
    .din0(din0), .din1(din1), .din2(din2),
    .outvalid(outvalid), .dout(dout), .cpsel(cpsel));

  gamma_cp_serializer #(.DATA_WIDTH(10), .NUM_CP(2), .CPSEL_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .ce(ce2), .inpvalid(iv2), .inpready(ir2),
    .din0(a0), .din1(a1), .din2(a2),
    .outvalid(ov2), .dout(do2), .cpsel(cs2));

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  // Model: FIFO of whole pixels (max 2) and the index of the next plane to send.
  logic [29:0] mq[$];
  int          mpl;
  logic        eov;
  logic [9:0]  edout;
  logic [1:0]  ecs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpl = 0; eov = 1'b0; edout = '0; ecs = '0;
  endtask

  task automatic tick(input logic v, input logic c, input logic [9:0] d0, d1, d2);
    logic        push;
    logic [29:0] px;
    inpvalid = v; ce = c; din0 = d0; din1 = d1; din2 = d2;
    #1;
    chk("inpready", inpready, logic'(c && mq.size() != 2));
    if (v && !inpready) stalls++;
    @(posedge clk);
    if (c) begin
      push = v && mq.size() != 2;
      if (mq.size() > 0) begin
        px    = mq[0];
        eov   = 1'b1;
        edout = px[mpl*10 +: 10];
        ecs   = 2'(mpl);
        mpl++;
        if (mpl == 3) begin
          void'(mq.pop_front());
          mpl = 0;
        end
      end else begin
        eov = 1'b0;
      end
      if (push) mq.push_back({d2, d1, d0});
    end
    #1;
    chk("outvalid", outvalid, eov);
    chk("dout", dout, edout);
    chk("cpsel", cpsel, ecs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 10'h0, 10'h0, 10'h0);
  endtask

  logic [9:0] e2d [5];
  logic [1:0] e2c [5];

  initial begin
    rst = 1'b1; ce = 1'b1; inpvalid = 1'b0; din0 = '0; din1 = '0; din2 = '0;
    ce2 = 1'b1; iv2 = 1'b0; a0 = '0; a1 = '0; a2 = '0;
    model_reset();
    #2;
    chk("rst_inpready", inpready, 1'b0);
    chk("rst_outvalid", outvalid, 1'b0);
    chk("rst_dout", dout, 10'h0);
    chk("rst_cpsel", cpsel, 2'd0);
    chk("rst_ir2", ir2, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single pixel latency and beat order
    tick(1'b1, 1'b1, 10'h011, 10'h022, 10'h033);
    idle(1); chk("t1_b0", {outvalid, dout, cpsel}, {1'b1, 10'h011, 2'd0});
    idle(1); chk("t1_b1", {outvalid, dout, cpsel}, {1'b1, 10'h022, 2'd1});
    idle(1); chk("t1_b2", {outvalid, dout, cpsel}, {1'b1, 10'h033, 2'd2});
    idle(1); chk("t1_done", outvalid, 1'b0);

    // Saturating source
    for (int i = 0; i < 18; i++) tick(1'b1, 1'b1, 10'(i), 10'(i + 100), 10'(i + 200));
    chk("t2_stalls_seen", logic'(stalls > 0), 1'b1);
    idle(8);

    // ce low mid-pixel
    tick(1'b1, 1'b1, 10'h101, 10'h102, 10'h103);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 10'h3aa, 10'h3bb, 10'h3cc);
      chk("t3_hold", {outvalid, dout, cpsel}, {1'b1, 10'h102, 2'd1});
    end
    idle(1); chk("t3_b2", {outvalid, dout, cpsel}, {1'b1, 10'h103, 2'd2});
    idle(1);

    // Async reset mid-pixel with a second pixel buffered
    tick(1'b1, 1'b1, 10'h0a1, 10'h0a2, 10'h0a3);
    tick(1'b1, 1'b1, 10'h0b1, 10'h0b2, 10'h0b3);
    inpvalid = 1'b0;
    idle(1);
    #3; rst = 1'b1; #1;
    chk("t4_async", {outvalid, dout, cpsel, inpready}, 14'h0);
    model_reset();
    @(posedge clk); #1; rst = 1'b0;
    tick(1'b1, 1'b1, 10'h007, 10'h008, 10'h009);
    idle(1); chk("t4_restart", {outvalid, dout, cpsel}, {1'b1, 10'h007, 2'd0});
    idle(3);

    // Random traffic
    for (int i = 0; i < 300; i++)
      tick(1'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
           10'($urandom), 10'($urandom), 10'($urandom));
    idle(8);

    // NUM_CP=2: back-to-back pixels A and B
    e2d = '{10'h1a0, 10'h1a1, 10'h2b0, 10'h2b1, 10'h000};
    e2c = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    iv2 = 1'b1; a0 = 10'h1a0; a1 = 10'h1a1; a2 = 10'h3ff;
    #1; chk("t5_ready_a", ir2, 1'b1);
    @(posedge clk); #1;
    a0 = 10'h2b0; a1 = 10'h2b1; a2 = 10'h155;
    #1; chk("t5_ready_b", ir2, 1'b1);
    @(posedge clk); #1;
    iv2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) chk("t5_beat", {ov2, do2, cs2}, {1'b1, e2d[k], e2c[k]});
      else       chk("t5_done", ov2, 1'b0);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
